// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: drives pll_rst, qualifies the synchronised lock,
// retries a bounded number of times, and generates phase-aligned clock enables in RUN.
module pll_lock_supervisor #(
  parameter int NUM_CH           = 4,
  parameter int DIV_W            = 16,
  parameter int RST_CYC          = 32,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 3
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    pll_locked,
  input  logic                    cfg_load,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH*DIV_W-1:0] div_phase,
  output logic                    pll_rst,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic                    fault,
  output logic [2:0]              retry_cnt,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLLRST = 3'd1,
    S_WAIT   = 3'd2,
    S_QUAL   = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // One counter serves PLLRST hold, WAIT timeout and QUAL stability; it is cleared on every state change.
  localparam int CNT_MAX = (RST_CYC > LOCK_TIMEOUT_CYC)
    ? ((RST_CYC > LOCK_STABLE_CYC) ? RST_CYC : LOCK_STABLE_CYC)
    : ((LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       retry_d;
  logic             latch, do_retry;
  logic             lock_m, lock_s;

  logic [DIV_W-1:0] ratio_q [NUM_CH];
  logic [DIV_W-1:0] ph_q    [NUM_CH];
  logic [DIV_W-1:0] ratio_d [NUM_CH];
  logic [DIV_W-1:0] ph_d    [NUM_CH];
  logic [NUM_CH-1:0] ce_d;

  assign state = cur;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    nxt      = cur;
    cnt_d    = cnt;
    retry_d  = retry_cnt;
    latch    = 1'b0;
    do_retry = 1'b0;
    if (!enable) begin
      nxt     = S_IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          nxt     = S_PLLRST;
          cnt_d   = '0;
          retry_d = '0;
        end
        S_PLLRST: begin
          if (cnt == RST_LAST) begin
            nxt   = S_WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            nxt   = S_QUAL;
            cnt_d = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            do_retry = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_QUAL: begin
          if (!lock_s) begin
            nxt   = S_WAIT;
            cnt_d = '0;
          end else if (cnt == STABLE_LAST) begin
            nxt   = S_RUN;
            cnt_d = '0;
            latch = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // Lock loss wins over a same-cycle cfg_load.
          if (!lock_s) begin
            do_retry = 1'b1;
          end else if (cfg_load) begin
            latch = 1'b1;
          end
        end
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
      if (do_retry) begin
        cnt_d = '0;
        if (retry_cnt == 3'(MAX_RETRY)) begin
          nxt = S_FAULT;
        end else begin
          nxt     = S_PLLRST;
          retry_d = retry_cnt + 3'd1;
        end
      end
    end
  end

  // Phase counters hold (P+k) mod R for the current RUN cycle; ce is registered from the next value.
  always_comb begin
    logic [DIV_W-1:0] r_in, p_in, r_new, p_new;
    ce_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      r_in  = div_ratio[i*DIV_W +: DIV_W];
      p_in  = div_phase[i*DIV_W +: DIV_W];
      r_new = (r_in == '0) ? DIV_W'(1) : r_in;
      p_new = (p_in < r_new) ? p_in : '0;
      ratio_d[i] = ratio_q[i];
      ph_d[i]    = ph_q[i];
      if (latch) begin
        ratio_d[i] = r_new;
        ph_d[i]    = p_new;
      end else if (cur == S_RUN && nxt == S_RUN) begin
        ph_d[i] = (ph_q[i] == ratio_q[i] - DIV_W'(1)) ? '0 : ph_q[i] + DIV_W'(1);
      end
      ce_d[i] = (nxt == S_RUN) && (ph_d[i] == ratio_d[i] - DIV_W'(1));
    end
  end

  // ready is a level qualifier, not a handshake: it is high exactly while the state is RUN.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      cur       <= S_IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      ce        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ratio_q[i] <= '0;
        ph_q[i]    <= '0;
      end
    end else begin
      cur       <= nxt;
      cnt       <= cnt_d;
      retry_cnt <= retry_d;
      pll_rst   <= (nxt == S_IDLE) || (nxt == S_PLLRST) || (nxt == S_FAULT);
      ready     <= (nxt == S_RUN);
      fault     <= (nxt == S_FAULT);
      ce        <= ce_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ratio_q[i] <= ratio_d[i];
        ph_q[i]    <= ph_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: table-driven enable patterns, hand-written lock/retry
// sequences, and randomized cfg_load traffic checked against an arithmetic model.
module tb_pll_lock_supervisor;

  localparam int NUM_CH  = 4;
  localparam int DIV_W   = 16;
  localparam int RST_C   = 32;
  localparam int TO_C    = 64;
  localparam int STAB_C  = 1024;
  localparam int MAX_R   = 3;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    pll_locked;
  logic                    cfg_load;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH*DIV_W-1:0] div_phase;
  logic                    pll_rst;
  logic                    ready;
  logic [NUM_CH-1:0]       ce;
  logic                    fault;
  logic [2:0]              retry_cnt;
  logic [2:0]              state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] ratio;
    logic [15:0] phase;
    logic [11:0] exp;   // bit k = expected ce in cycle k after the latch
  } vec_t;
  vec_t vecs [12];

  logic [NUM_CH-1:0] exp_q [$];

  pll_lock_supervisor #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_CYC(RST_C),
    .LOCK_TIMEOUT_CYC(TO_C), .LOCK_STABLE_CYC(STAB_C), .MAX_RETRY(MAX_R)
  ) dut (
    .refclk(refclk), .rst(rst), .enable(enable), .pll_locked(pll_locked),
    .cfg_load(cfg_load), .div_ratio(div_ratio), .div_phase(div_phase),
    .pll_rst(pll_rst), .ready(ready), .ce(ce), .fault(fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int j, input logic [15:0] r, input logic [15:0] p);
    div_ratio[j*DIV_W +: DIV_W] = r;
    div_phase[j*DIV_W +: DIV_W] = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample 12 cycles starting at k=0 (current cycle), scrambling inputs without cfg_load.
  task automatic collect_group(input int g);
    logic [11:0] pat [NUM_CH];
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < NUM_CH; j++) pat[j][k] = ce[j];
      for (int j = 0; j < NUM_CH; j++)
        set_ch(j, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      tick();
    end
    for (int j = 0; j < NUM_CH; j++)
      check($sformatf("ce_pattern g%0d ch%0d", g, j), 32'(pat[j]), 32'(vecs[g*4+j].exp));
  endtask

  task automatic wait_ready(input int bound, output int edges);
    edges = 0;
    while (!ready && edges < bound) begin
      tick();
      edges++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, output int edges);
    edges = 0;
    while (state !== s && edges < bound) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n, e, qual_e, n_to, wait_len, mk;
    logic [2:0] prev;
    int mr [NUM_CH];
    int mp [NUM_CH];
    int rr [NUM_CH];
    int pp [NUM_CH];
    logic [NUM_CH-1:0] expv;
    logic load;

    vecs[0]  = '{16'd4,     16'd0,     12'h888};
    vecs[1]  = '{16'd4,     16'd2,     12'h222};
    vecs[2]  = '{16'd1,     16'd0,     12'hFFF};
    vecs[3]  = '{16'd0,     16'd5,     12'hFFF};
    vecs[4]  = '{16'd3,     16'd1,     12'h492};
    vecs[5]  = '{16'd5,     16'd4,     12'h421};
    vecs[6]  = '{16'd2,     16'd1,     12'h555};
    vecs[7]  = '{16'd3,     16'd7,     12'h924};
    vecs[8]  = '{16'd65535, 16'd65534, 12'h001};
    vecs[9]  = '{16'd6,     16'd5,     12'h041};
    vecs[10] = '{16'd7,     16'd0,     12'h040};
    vecs[11] = '{16'd0,     16'd0,     12'hFFF};

    rst = 1'b0; enable = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0;
    div_ratio = '0; div_phase = '0;
    for (int j = 0; j < NUM_CH; j++) set_ch(j, vecs[j].ratio, vecs[j].phase);
    repeat (3) tick();
    check("rst pll_rst", 32'(pll_rst), 1);
    check("rst ready", 32'(ready), 0);
    check("rst ce", 32'(ce), 0);
    check("rst fault", 32'(fault), 0);
    check("rst retry_cnt", 32'(retry_cnt), 0);
    check("rst state", 32'(state), 0);
    rst = 1'b1;
    tick();
    check("idle while disabled", 32'(state), 0);

    // Bring-up: PLLRST length, lock acquisition latency, first RUN pattern.
    enable = 1'b1;
    tick();
    check("enable -> PLLRST", 32'(state), 1);
    n = 0;
    while (state == 3'd1 && n < 200) begin
      n++;
      tick();
    end
    check("pll_rst cycles", 32'(n), RST_C);
    check("pll_rst low in WAIT", 32'(pll_rst), 0);
    check("state WAIT", 32'(state), 2);
    repeat (10) tick();
    pll_locked = 1'b1;
    e = 0; qual_e = 0;
    while (!ready && e < 3000) begin
      tick();
      e++;
      if (state == 3'd3 && qual_e == 0) qual_e = e;
    end
    check("QUAL entry edge", 32'(qual_e), 3);
    check("ready edge", 32'(e), 2 + 1 + STAB_C);
    check("state RUN", 32'(state), 4);
    check("retry after lock", 32'(retry_cnt), 0);

    // Table-driven ce patterns: group 0 latched on RUN entry, later groups via cfg_load.
    collect_group(0);
    for (int g = 1; g < 3; g++) begin
      for (int j = 0; j < NUM_CH; j++) set_ch(j, vecs[g*4+j].ratio, vecs[g*4+j].phase);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      collect_group(g);
    end

    // Randomized cfg_load traffic against the (P+k) mod R model.
    mk = 0;
    for (int c = 0; c < 300; c++) begin
      load = (c == 0) || ($urandom_range(0, 7) == 0);
      for (int j = 0; j < NUM_CH; j++) begin
        rr[j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12));
        pp[j] = $urandom_range(0, 15);
        set_ch(j, 16'(rr[j]), 16'(pp[j]));
      end
      cfg_load = load;
      if (load) begin
        for (int j = 0; j < NUM_CH; j++) begin
          mr[j] = (rr[j] == 0) ? 1 : rr[j];
          mp[j] = (pp[j] < mr[j]) ? pp[j] : 0;
        end
        mk = 0;
      end else begin
        mk++;
      end
      tick();
      expv = '0;
      for (int j = 0; j < NUM_CH; j++)
        if ((mp[j] + mk) % mr[j] == mr[j] - 1) expv[j] = 1'b1;
      exp_q.push_back(expv);
      check("rand ce", 32'(ce), 32'(exp_q.pop_front()));
      check("rand ready", 32'(ready), 1);
    end
    cfg_load = 1'b0;

    // Lock loss in RUN with cfg_load on the same edge: relock wins, load ignored.
    pll_locked = 1'b0;
    tick();
    check("ready after loss e1", 32'(ready), 1);
    tick();
    check("ready after loss e2", 32'(ready), 1);
    set_ch(0, 16'd3, 16'd1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("loss e3 state", 32'(state), 1);
    check("loss e3 ready", 32'(ready), 0);
    check("loss e3 ce", 32'(ce), 0);
    check("loss e3 retry", 32'(retry_cnt), 1);
    check("loss e3 pll_rst", 32'(pll_rst), 1);
    pll_locked = 1'b1;
    wait_ready(3000, e);
    check("relock ready", 32'(ready), 1);
    check("relock state", 32'(state), 4);
    check("relock retry", 32'(retry_cnt), 1);

    enable = 1'b0;
    tick();
    check("disable state", 32'(state), 0);
    check("disable retry", 32'(retry_cnt), 0);
    check("disable ready", 32'(ready), 0);

    // Lock glitch during qualification restarts the stable count.
    enable = 1'b1;
    wait_state(3'd3, 200, e);
    check("reach QUAL", 32'(state), 3);
    n = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (state != 3'd3) n++;
    end
    check("stay QUAL 500", 32'(n), 0);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(3'd2, 10, e);
    check("glitch -> WAIT edges", 32'(e), 2);
    wait_state(3'd3, 10, e);
    check("back to QUAL", 32'(state), 3);
    wait_ready(3000, e);
    check("requal edges", 32'(e), STAB_C);
    check("requal retry", 32'(retry_cnt), 0);

    // enable=0 on the same edge as lock loss goes to IDLE.
    pll_locked = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("disable beats loss", 32'(state), 0);
    check("disable beats loss retry", 32'(retry_cnt), 0);

    // No lock at all: four timeouts then FAULT.
    tick();
    enable = 1'b1;
    n_to = 0; wait_len = 0; n = 0;
    while (state != 3'd5 && n < 3000) begin
      prev = state;
      tick();
      n++;
      if (state == 3'd2 && n_to == 0) wait_len++;
      if (prev == 3'd2 && state != 3'd2) begin
        n_to++;
        if (n_to < 4) check($sformatf("retry after timeout %0d", n_to), 32'(retry_cnt), 32'(n_to));
      end
    end
    check("timeouts", 32'(n_to), MAX_R + 1);
    check("WAIT length", 32'(wait_len), TO_C);
    check("fault state", 32'(state), 5);
    check("fault flag", 32'(fault), 1);
    check("fault pll_rst", 32'(pll_rst), 1);
    check("fault retry", 32'(retry_cnt), 3);
    check("fault ready", 32'(ready), 0);
    pll_locked = 1'b1;
    repeat (20) tick();
    check("fault sticky", 32'(state), 5);
    check("fault ce", 32'(ce), 0);
    enable = 1'b0;
    tick();
    check("fault exit state", 32'(state), 0);
    check("fault exit flag", 32'(fault), 0);
    check("fault exit retry", 32'(retry_cnt), 0);
    check("fault exit pll_rst", 32'(pll_rst), 1);

    // Asynchronous reset mid-operation.
    enable = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    check("async rst state", 32'(state), 0);
    check("async rst pll_rst", 32'(pll_rst), 1);
    tick();
    rst = 1'b1;
    tick();
    check("restart PLLRST", 32'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises an external PLL's reset/lock handshake from the free-running reference clock and generates NUM_CH phase-programmable clock-enable strobes. The strobes are valid only while lock is qualified. Sits beside the PLL wrapper:
- drives the PLL `rst`;
- consumes its `locked`;
- gives downstream logic a single `ready` qualifier, automatic relock with bounded retries, and a sticky fault.

## Interface
Parameters:
- NUM_CH, 4: number of clock-enable channels (1..8)
- DIV_W, 16: width of per-channel divide ratio and phase
- RST_CYC, 32: cycles `pll_rst` is held high per reset attempt (≥1)
- LOCK_TIMEOUT_CYC, 65536: max cycles to wait for first lock after an attempt
- LOCK_STABLE_CYC, 1024: consecutive synchronised-lock cycles required to qualify
- MAX_RETRY, 3: relock attempts allowed before fault

Ports:
- refclk  in  1  sole clock, free-running reference
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = run supervisor; 0 = return to IDLE
- pll_locked  in  1  raw PLL lock, asynchronous to refclk
- cfg_load  in  1  one-cycle strobe: resample ratios/phases, realign channels
- div_ratio  in  NUM_CH*DIV_W  channel i ratio in bits [i*DIV_W +: DIV_W]
- div_phase  in  NUM_CH*DIV_W  channel i initial phase, same packing
- pll_rst  out  1  active-high reset to PLL
- ready  out  1  lock qualified, state RUN
- ce  out  NUM_CH  per-channel clock-enable strobes
- fault  out  1  retries exhausted (sticky until enable=0)
- retry_cnt  out  3  relock attempts used
- state  out  3  FSM state encoding (debug)

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give lock_s. Nothing else samples the raw input.
- FSM states and encodings:
  - IDLE=0
  - PLLRST=1
  - WAIT=2
  - QUAL=3
  - RUN=4
  - FAULT=5
- Priority: enable=0 forces IDLE next cycle from any state. retry_cnt is cleared in IDLE.
- IDLE: pll_rst=1. Goes to PLLRST when enable=1.
- PLLRST: pll_rst=1 for exactly RST_CYC cycles, then goes to WAIT.
- WAIT: pll_rst=0. The timeout counter increments each cycle.
  - lock_s=1 → QUAL.
  - Counter reaching LOCK_TIMEOUT_CYC → RETRY.
- QUAL: counts consecutive lock_s=1 cycles.
  - lock_s=0 → WAIT, with both counters cleared.
  - Count reaches LOCK_STABLE_CYC → RUN.
- RUN: ready=1, ce active. lock_s=0 → RETRY.
- RETRY (a transition, not a state):
  - If retry_cnt==MAX_RETRY → FAULT.
  - Otherwise retry_cnt+1 → PLLRST.
- FAULT: pll_rst=1, fault=1, ce=0, ready=0. Exit only via enable=0.
- Clock enables, per channel:
  - R = max(div_ratio_i, 1).
  - P = div_phase_i if div_phase_i < R, else 0.
  - Both are latched on RUN entry and on cfg_load while in RUN.
  - Cycle k is the k-th RUN cycle since the latch; the first RUN cycle, or the cycle after cfg_load, is k=0.
  - ce[i]=1 in cycle k iff (P+k) mod R == R-1.
  - R=1 gives ce[i] constantly 1 in RUN.
  - Counter wraps R-1 → 0 with no overflow beyond DIV_W.
- cfg_load outside RUN is ignored. Ratio/phase inputs changing without cfg_load have no effect until the next latch.
- ce=0 and ready=0 in every state other than RUN.

## Timing
- Reset values (rst low, asynchronous):
  - pll_rst=1
  - ready=0, ce=0, fault=0
  - retry_cnt=0
  - state=IDLE
  - all counters 0
- All outputs are registered. ready, ce and state change on the same edge as the state transition.
- enable rising: state=PLLRST on the next edge. pll_rst stays 1 through RST_CYC PLLRST cycles.
- Lock acquisition: pll_locked rising reaches lock_s after 2 edges. QUAL is entered on the 3rd edge. RUN (ready=1) follows LOCK_STABLE_CYC edges later.
- Lock loss in RUN: pll_locked falling → ready=0, ce=0 and state=PLLRST on the 3rd edge.
- cfg_load asserted in cycle n: the new alignment takes effect with k=0 at cycle n+1.
- Simultaneous events:
  - enable=0 beats lock loss, timeout and cfg_load.
  - Lock loss beats cfg_load.
- rst deassertion is synchronous to refclk by the system. The block restarts in IDLE mid-operation regardless of state.

## Test plan
- Reset, enable=1, pll_locked rises 10 cycles after pll_rst falls (RST_CYC=32, LOCK_STABLE_CYC=1024):
  - pll_rst high exactly 32 cycles.
  - ready=1 exactly 2+1+1024 edges after pll_locked rise.
  - retry_cnt=0.
- In RUN, 4 channels with ratio/phase = 4/0, 4/2, 1/0, 0/5:
  - ch0 ce at k=3,7,11.
  - ch1 ce at k=1,5,9.
  - ch2 and ch3 high every cycle.
- Drop pll_locked in RUN:
  - ready/ce low on the 3rd edge.
  - retry_cnt=1, state=PLLRST.
  - Relock → RUN again.
- pll_locked never asserts, MAX_RETRY=3:
  - Four timeouts occur.
  - retry_cnt=3, then FAULT with fault=1 and pll_rst=1.
  - enable=0 → IDLE, fault=0, retry_cnt=0.
- Lock glitch in QUAL: pll_locked low 1 cycle at stable-count 500 → WAIT, and the qualification count restarts from 0.
- cfg_load in RUN changing ch0 from 4/0 to 3/1: ce at k=1,4,7 relative to the cycle after cfg_load. Same edge as lock loss → goes to PLLRST, the load is ignored.
